jtag_scan_controller: RTL and testbench



---
 rtl/jtag_scan_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_jtag_scan_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_controller.sv
// Host-side JTAG scan sequencer: walks the TAP from Run-Test/Idle through an
// IR or DR shift (up to MAX_LEN bits, LSB first), a TAP reset or a run of idle
// clocks, then returns the captured TDO bits on a valid/ready response port.
module jtag_scan_controller #(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned IDLE_CYCLES = 0
) (
  input  logic               clk_tck,
  input  logic               trst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_PRE   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_POST  = 3'd4;
  localparam logic [2:0] ST_RTI   = 3'd5;
  localparam logic [2:0] ST_RESP  = 3'd6;

  localparam logic [1:0] OP_DR   = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  // State and counter describe the cycle currently driven on the TAP pins.
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [5:0]         len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               bad_q, bad_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               len_ok;
  logic               to_resp;
  logic [CNT_W-1:0]   pre_last;

  assign len_ok = (cmd_len != 6'd0) && (CNT_W'(cmd_len) <= CNT_W'(MAX_LEN));

  // Next-state sequencing, then TMS/TDI for the upcoming cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    bad_d       = bad_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    to_resp     = 1'b0;

    case (op_q)
      OP_DR:   pre_last = CNT_W'(2);
      OP_IR:   pre_last = CNT_W'(3);
      default: pre_last = CNT_W'(5);
    endcase

    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(5)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          cmd_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          len_d       = cmd_len;
          data_d      = cmd_data;
          cap_d       = '0;
          bad_d       = 1'b0;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          case (cmd_op)
            OP_DR, OP_IR: begin
              if (len_ok) begin
                state_d = ST_PRE;
              end else begin
                // Rejected scan: one quiet cycle, then an error response.
                bad_d   = 1'b1;
                state_d = ST_RTI;
                cnt_d   = CNT_W'(1);
              end
            end
            OP_RST: state_d = ST_PRE;
            default: begin
              state_d = ST_RTI;
              cnt_d   = (cmd_len == 6'd0) ? CNT_W'(1) : CNT_W'(cmd_len);
            end
          endcase
        end
      end
      ST_PRE: begin
        if (cnt_q == pre_last) begin
          cnt_d = '0;
          if (op_q == OP_RST) begin
            to_resp = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        data_d = data_q >> 1;
        cap_d  = cap_q | (MAX_LEN'(tdo) << cnt_q);
        if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin
          state_d = ST_POST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_POST: begin
        if (cnt_q == CNT_W'(1)) begin
          if (IDLE_CYCLES == 0) begin
            to_resp = 1'b1;
          end else begin
            state_d = ST_RTI;
            cnt_d   = CNT_W'(IDLE_CYCLES);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RTI: begin
        if (cnt_q == CNT_W'(1)) begin
          to_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    if (to_resp) begin
      state_d     = ST_RESP;
      cnt_d       = '0;
      rsp_valid_d = 1'b1;
      rsp_data_d  = cap_q;
      rsp_err_d   = bad_q;
    end

    case (state_d)
      ST_INIT: tms_d = (cnt_d < CNT_W'(5));
      ST_PRE: begin
        case (op_d)
          OP_DR:   tms_d = (cnt_d == '0);
          OP_IR:   tms_d = (cnt_d < CNT_W'(2));
          default: tms_d = (cnt_d < CNT_W'(5));
        endcase
      end
      ST_SHIFT: begin
        tms_d = (cnt_d == CNT_W'(len_d) - CNT_W'(1));
        tdi_d = data_d[0];
      end
      ST_POST: tms_d = (cnt_d == '0);
      default: begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
      end
    endcase
  end

  // State register; reset parks the TAP pins with TMS high and reruns INIT.
  always_ff @(posedge clk_tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      op_q        <= OP_DR;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      bad_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      bad_q       <= bad_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_jtag_scan_controller.sv
// Bench for jtag_scan_controller: a behavioural TAP (IR=4 bits, IDCODE and
// BYPASS) or a TDI->TDO loopback sits on the pins; directed command vectors.
module tb_jtag_scan_controller;

  localparam logic [1:0] OP_DR   = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  localparam logic [3:0] T_TLR = 4'd0,  T_RTI = 4'd1,  T_SDR = 4'd2,  T_CDR = 4'd3;
  localparam logic [3:0] T_SHD = 4'd4,  T_E1D = 4'd5,  T_PDR = 4'd6,  T_E2D = 4'd7;
  localparam logic [3:0] T_UDR = 4'd8,  T_SIR = 4'd9,  T_CIR = 4'd10, T_SHI = 4'd11;
  localparam logic [3:0] T_E1I = 4'd12, T_PIR = 4'd13, T_E2I = 4'd14, T_UIR = 4'd15;

  localparam logic [3:0]  IR_IDC = 4'b1110;
  localparam logic [31:0] IDCODE = 32'h000FAF01;

  logic        clk_tck = 1'b0;
  logic        trst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        tms;
  logic        tdi;
  logic        tdo = 1'b0;
  logic        loop = 1'b0;

  int checks = 0;
  int errors = 0;

  jtag_scan_controller #(.MAX_LEN(32), .IDLE_CYCLES(0)) dut (
    .clk_tck   (clk_tck),
    .trst_n    (trst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 clk_tck = ~clk_tck;

  // Behavioural TAP; starts in an arbitrary state so INIT must recover it.
  logic [3:0]  tap_st = T_PDR;
  logic [3:0]  ir     = IR_IDC;
  logic [3:0]  ir_sr  = 4'h0;
  logic [31:0] dr_sr  = 32'h0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR : T_RTI;
      T_RTI:   return m ? T_SDR : T_RTI;
      T_SDR:   return m ? T_SIR : T_CDR;
      T_CDR:   return m ? T_E1D : T_SHD;
      T_SHD:   return m ? T_E1D : T_SHD;
      T_E1D:   return m ? T_UDR : T_PDR;
      T_PDR:   return m ? T_E2D : T_PDR;
      T_E2D:   return m ? T_UDR : T_SHD;
      T_UDR:   return m ? T_SDR : T_RTI;
      T_SIR:   return m ? T_TLR : T_CIR;
      T_CIR:   return m ? T_E1I : T_SHI;
      T_SHI:   return m ? T_E1I : T_SHI;
      T_E1I:   return m ? T_UIR : T_PIR;
      T_PIR:   return m ? T_E2I : T_PIR;
      T_E2I:   return m ? T_UIR : T_SHI;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  always @(posedge clk_tck) begin
    case (tap_st)
      T_CDR: dr_sr <= (ir == IR_IDC) ? IDCODE : 32'h0;
      T_SHD: dr_sr <= (ir == IR_IDC) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
      T_CIR: ir_sr <= 4'b0001;
      T_SHI: ir_sr <= {tdi, ir_sr[3:1]};
      T_UIR: ir    <= ir_sr;
      T_TLR: ir    <= IR_IDC;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  // TDO changes on the falling edge, as a real TAP does.
  always @(negedge clk_tck) begin
    if (loop)                tdo <= tdi;
    else if (tap_st == T_SHD) tdo <= dr_sr[0];
    else if (tap_st == T_SHI) tdo <= ir_sr[0];
    else                     tdo <= 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_tck);
    @(negedge clk_tck);
  endtask

  // Expected TMS per cycle (bit i = cycle i+1); unlisted cycles are 0.
  function automatic logic [127:0] exp_tms(input logic [1:0] op, input int len);
    logic [127:0] v = '0;
    int n = 0;
    if (op == OP_RST) begin
      for (int i = 0; i < 5; i++) v[7'(i)] = 1'b1;
    end else if ((op == OP_DR || op == OP_IR) && len >= 1 && len <= 32) begin
      v[7'(n)] = 1'b1; n++;
      if (op == OP_IR) begin v[7'(n)] = 1'b1; n++; end
      n += 2;
      n += len - 1;
      v[7'(n)] = 1'b1; n++;
      v[7'(n)] = 1'b1;
    end
    return v;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int w = 0;
    while (!cmd_ready && w < 20) begin tick(); w++; end
    check("issue_ready", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called in cycle 1; returns TMS trace and the posedge count to rsp_valid.
  task automatic wait_rsp(output logic [127:0] tr, output int lat, output logic busy_rdy);
    tr = '0;
    lat = -1;
    busy_rdy = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      if (rsp_valid) begin
        lat = c - 1;
        break;
      end
      tr[7'(c - 1)] = tms;
      if (cmd_ready) busy_rdy = 1'b1;
      tick();
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    check({tag, "_handshake"}, 128'({rsp_valid, cmd_ready}), 128'(2'b01));
    rsp_ready = 1'b0;
  endtask

  // Called at the negedge where trst_n has just been released.
  task automatic init_seq(input string tag);
    logic [5:0] seen;
    logic quiet_bad = 1'b0;
    for (int s = 0; s < 6; s++) begin
      seen[3'(s)] = tms;
      if (cmd_ready || rsp_valid) quiet_bad = 1'b1;
      tick();
    end
    check({tag, "_tms"}, 128'(seen), 128'(6'b011111));
    check({tag, "_quiet"}, 128'(quiet_bad), 128'(0));
    check({tag, "_ready"}, 128'({cmd_ready, tms, rsp_valid}), 128'(3'b100));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic        lp;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [127:0] tr;
    int           lat;
    logic         br;
    logic         bad;

    vecs[0]  = '{OP_DR,   6'd32, 32'h000FAF01, 1'b1, 32'h000FAF01, 1'b0, 37};
    vecs[1]  = '{OP_DR,   6'd5,  32'h00000015, 1'b1, 32'h00000015, 1'b0, 10};
    vecs[2]  = '{OP_DR,   6'd1,  32'h00000003, 1'b1, 32'h00000001, 1'b0, 6};
    vecs[3]  = '{OP_IR,   6'd4,  32'h0000000E, 1'b0, 32'h00000001, 1'b0, 10};
    vecs[4]  = '{OP_DR,   6'd32, 32'h00000000, 1'b0, 32'h000FAF01, 1'b0, 37};
    vecs[5]  = '{OP_DR,   6'd33, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1};
    vecs[6]  = '{OP_IR,   6'd0,  32'h0000000F, 1'b0, 32'h00000000, 1'b1, 1};
    vecs[7]  = '{OP_IR,   6'd4,  32'h0000000F, 1'b0, 32'h00000001, 1'b0, 10};
    vecs[8]  = '{OP_DR,   6'd8,  32'h000000A5, 1'b0, 32'h0000004A, 1'b0, 13};
    vecs[9]  = '{OP_RST,  6'd0,  32'h00000000, 1'b0, 32'h00000000, 1'b0, 6};
    vecs[10] = '{OP_DR,   6'd32, 32'h12345678, 1'b0, 32'h000FAF01, 1'b0, 37};
    vecs[11] = '{OP_IDLE, 6'd7,  32'h00000000, 1'b0, 32'h00000000, 1'b0, 7};
    vecs[12] = '{OP_IDLE, 6'd0,  32'h0000FFFF, 1'b0, 32'h00000000, 1'b0, 1};
    vecs[13] = '{OP_DR,   6'd32, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 37};
    vecs[14] = '{OP_IR,   6'd4,  32'h0000000E, 1'b0, 32'h00000001, 1'b0, 10};
    vecs[15] = '{OP_DR,   6'd16, 32'h00000000, 1'b0, 32'h0000AF01, 1'b0, 21};

    trst_n    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 6'd0;
    cmd_data  = 32'h0;
    rsp_ready = 1'b0;

    // Reset values, then the INIT walk into Run-Test/Idle.
    @(negedge clk_tck);
    @(negedge clk_tck);
    check("reset_ctl", 128'({tms, tdi, cmd_ready, rsp_valid, rsp_err}), 128'(5'b10000));
    check("reset_data", 128'(rsp_data), 128'(0));
    trst_n = 1'b1;
    init_seq("init");

    // Table of commands against the TAP model or the loopback.
    for (int i = 0; i < 16; i++) begin
      loop = vecs[i].lp;
      issue(vecs[i].op, vecs[i].len, vecs[i].data);
      wait_rsp(tr, lat, br);
      check($sformatf("v%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
      check($sformatf("v%0d_data", i), 128'(rsp_data), 128'(vecs[i].exp_data));
      check($sformatf("v%0d_err", i), 128'(rsp_err), 128'(vecs[i].exp_err));
      check($sformatf("v%0d_tms", i), tr, exp_tms(vecs[i].op, int'(vecs[i].len)));
      check($sformatf("v%0d_tap_rti", i), 128'(tap_st), 128'(T_RTI));
      check($sformatf("v%0d_busy_ready", i), 128'(br), 128'(0));
      handshake($sformatf("v%0d", i));
    end

    // Response back-pressure: everything holds, next accept right after release.
    loop = 1'b1;
    issue(OP_DR, 6'd8, 32'h0000003C);
    wait_rsp(tr, lat, br);
    check("hold_lat", 128'(lat), 128'(13));
    check("hold_data", 128'(rsp_data), 128'(32'h3C));
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!(rsp_valid && rsp_data == 32'h3C && !rsp_err && !tms && !cmd_ready)) bad = 1'b1;
      tick();
    end
    check("hold_stable", 128'(bad), 128'(0));
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = OP_DR;
    cmd_len   = 6'd4;
    cmd_data  = 32'h9;
    tick();
    check("hold_release", 128'({rsp_valid, cmd_ready}), 128'(2'b01));
    rsp_ready = 1'b0;
    tick();
    check("hold_next_accept", 128'({cmd_ready, tms}), 128'(2'b01));
    cmd_valid = 1'b0;
    wait_rsp(tr, lat, br);
    check("next_lat", 128'(lat), 128'(9));
    check("next_data", 128'(rsp_data), 128'(32'h9));
    handshake("next");

    // Reset at shift bit 10 of a 32-bit scan.
    loop = 1'b0;
    issue(OP_DR, 6'd32, 32'hFFFFFFFF);
    for (int k = 0; k < 13; k++) tick();
    check("mid_pre_tdi", 128'({tms, tdi}), 128'(2'b01));
    trst_n = 1'b0;
    #1;
    check("mid_reset_ctl", 128'({tms, tdi, cmd_ready, rsp_valid, rsp_err}), 128'(5'b10000));
    check("mid_reset_data", 128'(rsp_data), 128'(0));
    @(negedge clk_tck);
    trst_n = 1'b1;
    init_seq("reinit");
    issue(OP_DR, 6'd32, 32'h0);
    wait_rsp(tr, lat, br);
    check("post_reset_lat", 128'(lat), 128'(37));
    check("post_reset_idcode", 128'(rsp_data), 128'(IDCODE));
    check("post_reset_err", 128'(rsp_err), 128'(0));
    handshake("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
